// File: rtl/prim_ram_1p_arb_if.sv
// prim_ram_1p_arb_if: requester A/B request/response signals plus the shared RAM port.
// slave is the arbiter's view; master is the view of the requesters and the RAM macro.
interface prim_ram_1p_arb_if #(
   parameter int Width = 32,
   parameter int Depth = 128
);
   localparam int Aw = $clog2(Depth);

   logic             a_req_i;
   logic             a_gnt_o;
   logic             a_write_i;
   logic [Aw-1:0]    a_addr_i;
   logic [Width-1:0] a_wdata_i;
   logic [Width-1:0] a_wmask_i;
   logic             a_rvalid_o;
   logic [Width-1:0] a_rdata_o;

   logic             b_req_i;
   logic             b_gnt_o;
   logic             b_write_i;
   logic [Aw-1:0]    b_addr_i;
   logic [Width-1:0] b_wdata_i;
   logic [Width-1:0] b_wmask_i;
   logic             b_rvalid_o;
   logic [Width-1:0] b_rdata_o;

   logic             ram_req_o;
   logic             ram_write_o;
   logic [Aw-1:0]    ram_addr_o;
   logic [Width-1:0] ram_wdata_o;
   logic [Width-1:0] ram_wmask_o;
   logic [Width-1:0] ram_rdata_i;

   modport slave (
      input  a_req_i, a_write_i, a_addr_i, a_wdata_i, a_wmask_i,
      output a_gnt_o, a_rvalid_o, a_rdata_o,
      input  b_req_i, b_write_i, b_addr_i, b_wdata_i, b_wmask_i,
      output b_gnt_o, b_rvalid_o, b_rdata_o,
      output ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
      input  ram_rdata_i
   );

   modport master (
      output a_req_i, a_write_i, a_addr_i, a_wdata_i, a_wmask_i,
      input  a_gnt_o, a_rvalid_o, a_rdata_o,
      output b_req_i, b_write_i, b_addr_i, b_wdata_i, b_wmask_i,
      input  b_gnt_o, b_rvalid_o, b_rdata_o,
      input  ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
      output ram_rdata_i
   );
endinterface

// File: rtl/prim_ram_1p_arb.sv
// prim_ram_1p_arb: round-robin, same-cycle-grant arbiter sharing one 1-cycle-latency RAM port between A and B.
// Define PRIM_RAM_ARB_RDATA_REG_EN to register rvalid/rdata per port (read data at T+2 instead of T+1).
module prim_ram_1p_arb #(
   parameter int Width = 32,
   parameter int Depth = 128
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   prim_ram_1p_arb_if.slave bus
);
   localparam int Aw = $clog2(Depth);

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   port_e            prio_q, prio_d;
   logic             a_gnt, b_gnt;
   logic             ram_req, ram_write;
   logic [Aw-1:0]    ram_addr;
   logic [Width-1:0] ram_wdata, ram_wmask;
   logic             id0_valid_q;
   port_e            id0_owner_q;

   // A tie goes to prio_q; after any grant the loser becomes the next tie winner.
   always_comb begin
      a_gnt  = bus.a_req_i & (~bus.b_req_i | (prio_q == PORT_A));
      b_gnt  = bus.b_req_i & (~bus.a_req_i | (prio_q == PORT_B));
      prio_d = prio_q;
      if (a_gnt) begin
         prio_d = PORT_B;
      end else if (b_gnt) begin
         prio_d = PORT_A;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q <= PORT_A;
      end else begin
         prio_q <= prio_d;
      end
   end

   always_comb begin
      ram_write = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_wmask = '0;
      if (a_gnt) begin
         ram_write = bus.a_write_i;
         ram_addr  = bus.a_addr_i;
         ram_wdata = bus.a_wdata_i;
         ram_wmask = bus.a_wmask_i;
      end else if (b_gnt) begin
         ram_write = bus.b_write_i;
         ram_addr  = bus.b_addr_i;
         ram_wdata = bus.b_wdata_i;
         ram_wmask = bus.b_wmask_i;
      end
   end

   assign ram_req         = a_gnt | b_gnt;
   assign bus.a_gnt_o     = a_gnt;
   assign bus.b_gnt_o     = b_gnt;
   assign bus.ram_req_o   = ram_req;
   assign bus.ram_write_o = ram_write;
   assign bus.ram_addr_o  = ram_addr;
   assign bus.ram_wdata_o = ram_wdata;
   assign bus.ram_wmask_o = ram_wmask;

   // Stage 0 lines up with the RAM's read latency: it names the owner of ram_rdata_i next cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id0_valid_q <= 1'b0;
         id0_owner_q <= PORT_A;
      end else begin
         id0_valid_q <= ram_req & ~ram_write;
         id0_owner_q <= b_gnt ? PORT_B : PORT_A;
      end
   end

`ifdef PRIM_RAM_ARB_RDATA_REG_EN
   logic             id1_valid_q;
   port_e            id1_owner_q;
   logic [Width-1:0] a_rdata_q, b_rdata_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id1_valid_q <= 1'b0;
         id1_owner_q <= PORT_A;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         id1_valid_q <= id0_valid_q;
         id1_owner_q <= id0_owner_q;
         if (id0_valid_q && (id0_owner_q == PORT_A)) begin
            a_rdata_q <= bus.ram_rdata_i;
         end
         if (id0_valid_q && (id0_owner_q == PORT_B)) begin
            b_rdata_q <= bus.ram_rdata_i;
         end
      end
   end

   assign bus.a_rvalid_o = id1_valid_q & (id1_owner_q == PORT_A);
   assign bus.b_rvalid_o = id1_valid_q & (id1_owner_q == PORT_B);
   assign bus.a_rdata_o  = a_rdata_q;
   assign bus.b_rdata_o  = b_rdata_q;
`else
   assign bus.a_rvalid_o = id0_valid_q & (id0_owner_q == PORT_A);
   assign bus.b_rvalid_o = id0_valid_q & (id0_owner_q == PORT_B);
   assign bus.a_rdata_o  = bus.ram_rdata_i;
   assign bus.b_rdata_o  = bus.ram_rdata_i;
`endif

endmodule

// File: tb/tb_prim_ram_1p_arb.sv
// tb_prim_ram_1p_arb: random and directed traffic on both ports against a RAM model and a scoreboard.
// Expected reads come from a reference memory and a "last served" fairness rule.
module tb_prim_ram_1p_arb;
   localparam int W  = 32;
   localparam int D  = 128;
   localparam int AW = $clog2(D);
`ifdef PRIM_RAM_ARB_RDATA_REG_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   typedef struct packed {
      logic          idle;
      logic          write;
      logic [AW-1:0] addr;
      logic [W-1:0]  wdata;
      logic [W-1:0]  wmask;
   } cmd_t;

   typedef struct {
      logic [W-1:0] data;
      int unsigned  due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned cyc = 0;
   int total = 0;
   int bad = 0;

   logic [W-1:0] ram_mem [D] = '{default: '0};
   logic [W-1:0] ref_mem [D] = '{default: '0};

   cmd_t cmd_q [2][$];
   exp_t sb [2][$];
   cmd_t cur_cmd [2] = '{default: '0};
   logic cur_req [2] = '{1'b0, 1'b0};
   logic gnt_seen [2] = '{1'b0, 1'b0};
   logic pend [2] = '{1'b0, 1'b0};
   cmd_t pend_cmd [2] = '{default: '0};
   logic [W-1:0] last_rd [2] = '{default: '0};
   int last_srv = 1;

   prim_ram_1p_arb_if #(.Width(W), .Depth(D)) bus ();

   prim_ram_1p_arb #(.Width(W), .Depth(D)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM macro: 1-cycle read latency, bit-masked write.
   always @(posedge clk) begin
      if (bus.ram_req_o) begin
         if (bus.ram_write_o) begin
            ram_mem[bus.ram_addr_o] <= (ram_mem[bus.ram_addr_o] & ~bus.ram_wmask_o) |
                                       (bus.ram_wdata_o & bus.ram_wmask_o);
         end else begin
            bus.ram_rdata_i <= ram_mem[bus.ram_addr_o];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic cmd_t get_port(input int p);
      cmd_t c;
      if (p == 0) c = '{!bus.a_req_i, bus.a_write_i, bus.a_addr_i, bus.a_wdata_i, bus.a_wmask_i};
      else        c = '{!bus.b_req_i, bus.b_write_i, bus.b_addr_i, bus.b_wdata_i, bus.b_wmask_i};
      return c;
   endfunction

   task automatic apply(input int p, input cmd_t c);
      if (p == 0) begin
         bus.a_req_i = !c.idle; bus.a_write_i = c.write; bus.a_addr_i = c.addr;
         bus.a_wdata_i = c.wdata; bus.a_wmask_i = c.wmask;
      end else begin
         bus.b_req_i = !c.idle; bus.b_write_i = c.write; bus.b_addr_i = c.addr;
         bus.b_wdata_i = c.wdata; bus.b_wmask_i = c.wmask;
      end
   endtask

   // Driver: a port moves to its next command only once the current one was accepted.
   always @(posedge clk) begin
      #1;
      for (int p = 0; p < 2; p++) begin
         if (!cur_req[p] || gnt_seen[p]) begin
            cmd_t c;
            c = '0;
            c.idle = 1'b1;
            if (cmd_q[p].size() > 0) c = cmd_q[p].pop_front();
            cur_cmd[p] = c;
            cur_req[p] = !c.idle;
            apply(p, c);
         end
      end
   end

   // Monitor / reference model.
   always @(negedge clk) begin
      logic ga, gb, rv, exp_v;
      logic [W-1:0] rd;
      cmd_t g;
      exp_t e;
      int gp;
      if (!rst_n) begin
         chk("a_rvalid_in_reset", bus.a_rvalid_o, 0);
         chk("b_rvalid_in_reset", bus.b_rvalid_o, 0);
         chk("a_gnt_in_reset", bus.a_gnt_o, cur_req[0]);
         chk("b_gnt_in_reset", bus.b_gnt_o, cur_req[1] && !cur_req[0]);
         sb[0].delete();
         sb[1].delete();
         last_srv = 1;
         gnt_seen = '{1'b0, 1'b0};
         pend = '{1'b0, 1'b0};
         last_rd = '{default: '0};
      end else begin
         for (int p = 0; p < 2; p++) begin
            rv = (p == 0) ? bus.a_rvalid_o : bus.b_rvalid_o;
            rd = (p == 0) ? bus.a_rdata_o : bus.b_rdata_o;
            exp_v = (sb[p].size() > 0) && (sb[p][0].due == cyc);
            chk((p == 0) ? "a_rvalid" : "b_rvalid", rv, exp_v);
            if (exp_v) begin
               e = sb[p].pop_front();
               if (rv) chk((p == 0) ? "a_rdata" : "b_rdata", rd, e.data);
               last_rd[p] = e.data;
            end
`ifdef PRIM_RAM_ARB_RDATA_REG_EN
            else if (!rv) chk((p == 0) ? "a_rdata_hold" : "b_rdata_hold", rd, last_rd[p]);
`endif
            if (pend[p]) begin
               assert (get_port(p) == pend_cmd[p])
                  else $error("port %0d changed request while waiting for grant", p);
            end
         end

         ga = cur_req[0] && (!cur_req[1] || last_srv == 1);
         gb = cur_req[1] && !ga;
         chk("a_gnt", bus.a_gnt_o, ga);
         chk("b_gnt", bus.b_gnt_o, gb);
         chk("ram_req", bus.ram_req_o, ga || gb);
         if (ga || gb) begin
            gp = ga ? 0 : 1;
            g = cur_cmd[gp];
            chk("ram_write", bus.ram_write_o, g.write);
            chk("ram_addr", bus.ram_addr_o, g.addr);
            if (g.write) begin
               chk("ram_wdata", bus.ram_wdata_o, g.wdata);
               chk("ram_wmask", bus.ram_wmask_o, g.wmask);
               ref_mem[g.addr] = (ref_mem[g.addr] & ~g.wmask) | (g.wdata & g.wmask);
            end else begin
               sb[gp].push_back('{ref_mem[g.addr], cyc + LAT});
            end
            last_srv = gp;
         end else begin
            chk("ram_write_idle", bus.ram_write_o, 0);
            chk("ram_addr_idle", bus.ram_addr_o, 0);
            chk("ram_wdata_idle", bus.ram_wdata_o, 0);
            chk("ram_wmask_idle", bus.ram_wmask_o, 0);
         end
         gnt_seen[0] = ga;
         gnt_seen[1] = gb;
         for (int p = 0; p < 2; p++) begin
            pend[p] = cur_req[p] && !((p == 0) ? ga : gb);
            pend_cmd[p] = get_port(p);
         end
      end
   end

   function automatic cmd_t mk(input logic w, input int unsigned addr,
                               input logic [W-1:0] wd, input logic [W-1:0] m);
      cmd_t c;
      c.idle = 1'b0; c.write = w; c.addr = AW'(addr); c.wdata = wd; c.wmask = m;
      return c;
   endfunction

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(cmd_q[0].size() == 0 && cmd_q[1].size() == 0 && !cur_req[0] &&
                   !cur_req[1] && sb[0].size() == 0 && sb[1].size() == 0) && n < 2000);
      @(negedge clk);
      chk({"drain_", tag}, (n < 2000), 1);
   endtask

   initial begin
      int n;
      cmd_t c;
      // Both ports request while reset is held; A must win right after release.
      cmd_q[0].push_back(mk(0, 0, '0, '0));
      cmd_q[1].push_back(mk(0, 0, '0, '0));
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_drain("reset");

      cmd_q[0].push_back(mk(1, 5, 32'hDEADBEEF, '1));
      cmd_q[0].push_back(mk(0, 5, '0, '0));
      wait_drain("single");

      cmd_q[0].push_back(mk(1, 1, 32'h11, '1));
      cmd_q[0].push_back(mk(1, 2, 32'h22, '1));
      wait_drain("preload");
      for (int i = 0; i < 6; i++) begin
         cmd_q[0].push_back(mk(0, 1, '0, '0));
         cmd_q[1].push_back(mk(0, 2, '0, '0));
      end
      wait_drain("contention");

      cmd_q[1].push_back(mk(0, 2, '0, '0));
      wait_drain("b_alone");
      cmd_q[0].push_back(mk(0, 1, '0, '0));
      cmd_q[1].push_back(mk(0, 2, '0, '0));
      wait_drain("fair");

      cmd_q[0].push_back(mk(1, 3, 32'h12345678, '1));
      cmd_q[0].push_back(mk(1, 3, 32'hFFFFFFFF, 32'h0000FFFF));
      cmd_q[0].push_back(mk(0, 3, '0, '0));
      wait_drain("masked");
      chk("masked_ref", ref_mem[3], 32'h1234FFFF);

      for (int i = 0; i < 250; i++) begin
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(3) == 0) begin
               c = '0;
               c.idle = 1'b1;
            end else begin
               c = mk(1'($urandom_range(1)), $urandom_range(D - 1), $urandom, $urandom);
            end
            cmd_q[p].push_back(c);
         end
      end
      wait_drain("random");

      cmd_q[1].push_back(mk(0, 2, '0, '0));
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!gnt_seen[1] && n < 50);
      chk("b_grant_before_reset", (n < 50), 1);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      cmd_q[0].push_back(mk(0, 2, '0, '0));
      cmd_q[1].push_back(mk(0, 1, '0, '0));
      wait_drain("after_reset");

      chk("sb_a_empty", sb[0].size(), 0);
      chk("sb_b_empty", sb[1].size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
